// File: rtl/ram_upload_arbiter_if.sv
// ram_upload_arbiter_if: upload, CPU and RAM bus bundle for ram_upload_arbiter.
// upload_sum exists only when UPLOAD_CHECKSUM_EN is defined.
interface ram_upload_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 15
) ();
  logic                  ioctl_download;
  logic [16:0]           ioctl_addr;
  logic [31:0]           ioctl_dout;
  logic                  ioctl_wr;
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [3:0]            cpu_be;
  logic                  cpu_ack;
  logic [31:0]           cpu_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [3:0]            ram_be;
  logic                  ram_we;
  logic [31:0]           ram_rdata;
  logic                  cpu_reset;
`ifdef UPLOAD_CHECKSUM_EN
  logic [31:0]           upload_sum;
`endif

  // Arbiter side: owns the RAM port and the CPU completion/reset signals.
  modport master (
    input  ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  ram_rdata,
    output cpu_ack, cpu_rdata,
    output ram_addr, ram_wdata, ram_be, ram_we,
    output cpu_reset
`ifdef UPLOAD_CHECKSUM_EN
    , output upload_sum
`endif
  );

  // Environment side: uploader, CPU and RAM.
  modport slave (
    output ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output ram_rdata,
    input  cpu_ack, cpu_rdata,
    input  ram_addr, ram_wdata, ram_be, ram_we,
    input  cpu_reset
`ifdef UPLOAD_CHECKSUM_EN
    , input upload_sum
`endif
  );
endinterface

// File: rtl/ram_upload_arbiter.sv
// ram_upload_arbiter: shares one single-port RAM between a program uploader
// and a CPU, holding the CPU in reset during and shortly after an upload.
// Optional feature macro: UPLOAD_CHECKSUM_EN (adds upload_sum).
module ram_upload_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned RELEASE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_upload_arbiter_if.master  bus
);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, CPU_RD, LOAD, RELEASE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_rd_ack;
  logic                  w_rd_ack_nxt;
  logic [31:0]           r_cpu_rdata;
  logic                  w_wr_ack;
  logic [ADDR_WIDTH-1:0] w_ioctl_waddr;
  logic                  w_unused_addr_lsb;

  // Byte address to word address; bits above the RAM range are dropped.
  assign w_ioctl_waddr     = bus.ioctl_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr_lsb = ^bus.ioctl_addr[1:0];

  // State and release counter; reset lands in RELEASE so the CPU boots late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RELEASE;
      r_cnt   <= CNT_W'(RELEASE_CYCLES);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Read completion: capture RAM data one cycle after the address was driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ack    <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_rd_ack <= w_rd_ack_nxt;
      if (w_rd_ack_nxt) begin
        r_cpu_rdata <= bus.ram_rdata;
      end
    end
  end

  // Next state and RAM port mux; an active download always wins.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rd_ack_nxt  = 1'b0;
    w_wr_ack      = 1'b0;
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_be    = 4'h0;
    bus.ram_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ioctl_download) begin
          w_state_nxt = LOAD;
        end else if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            bus.ram_we = 1'b1;
            bus.ram_be = bus.cpu_be;
            w_wr_ack   = 1'b1;
          end else begin
            w_state_nxt = CPU_RD;
          end
        end
      end
      CPU_RD: begin
        if (bus.ioctl_download) begin
          w_state_nxt = LOAD;
        end else begin
          w_rd_ack_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      LOAD: begin
        bus.ram_addr  = w_ioctl_waddr;
        bus.ram_wdata = bus.ioctl_dout;
        if (bus.ioctl_wr) begin
          bus.ram_we = 1'b1;
          bus.ram_be = 4'hF;
        end
        if (!bus.ioctl_download) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = CNT_W'(RELEASE_CYCLES);
        end
      end
      RELEASE: begin
        if (bus.ioctl_download) begin
          w_state_nxt = LOAD;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_ack   = w_wr_ack | r_rd_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_reset = (r_state == LOAD) || (r_state == RELEASE);

`ifdef UPLOAD_CHECKSUM_EN
  logic [31:0] r_upload_sum;

  // Running sum of upload words; restarts whenever a new LOAD begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upload_sum <= '0;
    end else if ((w_state_nxt == LOAD) && (r_state != LOAD)) begin
      r_upload_sum <= '0;
    end else if ((r_state == LOAD) && bus.ioctl_wr) begin
      r_upload_sum <= r_upload_sum + bus.ioctl_dout;
    end
  end

  assign bus.upload_sum = r_upload_sum;
`endif
endmodule
